// File: rtl/hazard_scoreboard_if.sv
// Handshake between the ID-stage decoder and the register-dependency scoreboard.
// The decoder side owns the ID fields and its stall verdict. The scoreboard side owns the hazard code and pipeline controls.
interface hazard_scoreboard_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_we;
  logic [4:0]       id_wreg;
  logic             pause_out;
  logic             flush;
  logic [1:0]       pause_in;
  logic             stall;
  logic             bubble;
  logic             busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_we, id_wreg, pause_out, flush,
    input  pause_in, stall, bubble, busy, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_we, id_wreg, pause_out, flush,
    output pause_in, stall, bubble, busy, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks destination registers of instructions past ID (EX/MEM/WB, no forwarding)
// and reports read-after-write hazards to the decoder; counts stall cycles, saturating.
module hazard_scoreboard #(
  parameter int HAZ_DEPTH = 3,
  parameter int CNT_W     = 32
) (
  input logic                clk,
  input logic                rst_n,
  hazard_scoreboard_if.slave sb
);

  logic [HAZ_DEPTH-1:0] ent_v_q;
  logic [HAZ_DEPTH-1:0] ent_v_d;
  logic [4:0]           ent_r_q [HAZ_DEPTH];
  logic [4:0]           ent_r_d [HAZ_DEPTH];
  logic [CNT_W-1:0]     stall_cnt_q;
  logic [CNT_W-1:0]     stall_cnt_d;
  logic                 hit_rs;
  logic                 hit_rt;
  logic                 stall_s;

  // Shift the in-flight window; a stalled, flushed or non-writing ID slot enters as a bubble.
  always_comb begin
    ent_v_d = '0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      ent_r_d[i] = 5'd0;
    end
    ent_v_d[0] = sb.id_valid & sb.id_we & (sb.id_wreg != 5'd0) & ~sb.pause_out & ~sb.flush;
    ent_r_d[0] = ent_v_d[0] ? sb.id_wreg : 5'd0;
    for (int i = 1; i < HAZ_DEPTH; i++) begin
      ent_v_d[i] = ent_v_q[i-1];
      ent_r_d[i] = ent_r_q[i-1];
    end
  end

  always_comb begin
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      hit_rs = hit_rs | (ent_v_q[i] & (ent_r_q[i] == sb.id_rs));
      hit_rt = hit_rt | (ent_v_q[i] & (ent_r_q[i] == sb.id_rt));
    end
    hit_rs = hit_rs & sb.id_valid & (sb.id_rs != 5'd0);
    hit_rt = hit_rt & sb.id_valid & (sb.id_rt != 5'd0);
  end

  // RS has priority; the decoder masks the RT code itself for I-types.
  always_comb begin
    if (!rst_n) begin
      sb.pause_in = 2'b00;
    end else if (hit_rs) begin
      sb.pause_in = 2'b01;
    end else if (hit_rt) begin
      sb.pause_in = 2'b10;
    end else begin
      sb.pause_in = 2'b00;
    end
  end

  assign stall_s   = rst_n & sb.id_valid & sb.pause_out & ~sb.flush;
  assign sb.stall  = stall_s;
  assign sb.bubble = rst_n & (stall_s | sb.flush);
  assign sb.busy   = |ent_v_q;

  always_comb begin
    if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  assign sb.stall_cnt = stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_v_q     <= '0;
      stall_cnt_q <= '0;
      for (int i = 0; i < HAZ_DEPTH; i++) begin
        ent_r_q[i] <= 5'd0;
      end
    end else begin
      ent_v_q     <= ent_v_d;
      stall_cnt_q <= stall_cnt_d;
      for (int i = 0; i < HAZ_DEPTH; i++) begin
        ent_r_q[i] <= ent_r_d[i];
      end
    end
  end

endmodule
